// File: rtl/ca_code_nco_if.sv
// ca_code_nco_if: seek handshake between a channel controller and ca_code_nco.
//   master (controller): drives seek_start / seek_target / seek_abort,
//                        observes seek_busy / seek_done / seek_err.
//   slave  (NCO):        the opposite directions.
//   seek_start   pulse, latch seek_target and begin a seek
//   seek_target  code_shift value to seek to
//   seek_abort   pulse, abandon a running seek
//   seek_busy    high while the seek engine is advancing
//   seek_done    one-cycle pulse, target reached
//   seek_err     one-cycle pulse, target out of range and rejected
interface ca_code_nco_if #(
  parameter int CS_WIDTH = 16
);
  logic                seek_start;
  logic [CS_WIDTH-1:0] seek_target;
  logic                seek_abort;
  logic                seek_busy;
  logic                seek_done;
  logic                seek_err;

  modport master (
    output seek_start, seek_target, seek_abort,
    input  seek_busy, seek_done, seek_err
  );

  modport slave (
    input  seek_start, seek_target, seek_abort,
    output seek_busy, seek_done, seek_err
  );
endinterface

// File: rtl/ca_code_nco.sv
// ca_code_nco: C/A code upsampler for one tracking channel.
// A chip-rate phase accumulator clocks a G1/G2 Gold-code generator; the
// generator output (early chip) feeds a delay line whose taps give the prompt
// and late chips at a runtime-programmable spacing. A sample counter
// (code_shift) wraps once per code period, restarting the generator and
// pulsing epoch. A seek engine free-runs the counter to a requested value.
// Ports:
//   clk, rst          sample clock, asynchronous active-high reset
//   enable_i          one new sample this cycle
//   prn_i             satellite PRN (1..32; 0 selects PRN 32)
//   inc_i             chip NCO phase increment
//   spacing_i         E-P / P-L spacing in samples, clamped to 1..MAX_SPACING
//   seek              seek handshake (ca_code_nco_if.slave)
//   code_shift_o      sample index within the code period
//   epoch_o           one-cycle pulse after code_shift wraps to 0
//   out_early_o / out_prompt_o / out_late_o   code chips at sample rate
//   epoch_count_o     epoch counter, present only with CA_NCO_EPOCH_COUNT_EN
// Optional feature macro: CA_NCO_EPOCH_COUNT_EN
module ca_code_nco #(
  parameter int CS_WIDTH       = 16,
  parameter int MAX_CODE_SHIFT = 16367,
  parameter int ACC_WIDTH      = 24,
  parameter int MAX_SPACING    = 16,
  parameter int SP_WIDTH       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [4:0]           prn_i,
  input  logic [ACC_WIDTH-1:0] inc_i,
  input  logic [SP_WIDTH-1:0]  spacing_i,
  ca_code_nco_if.slave         seek,
  output logic [CS_WIDTH-1:0]  code_shift_o,
  output logic                 epoch_o,
  output logic                 out_early_o,
  output logic                 out_prompt_o,
  output logic                 out_late_o
`ifdef CA_NCO_EPOCH_COUNT_EN
  ,
  output logic [15:0]          epoch_count_o
`endif
);

  localparam int                  DL     = 2 * MAX_SPACING;
  localparam logic [CS_WIDTH-1:0] MAX_CS = CS_WIDTH'(MAX_CODE_SHIFT);

  typedef enum logic [1:0] {S_IDLE, S_SEEK, S_DONE} state_t;

  state_t               state_q;
  logic [CS_WIDTH-1:0]  cs_q, cs_d, target_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH:0]   sum;
  logic [10:1]          g1_q, g2_q;
  logic [3:0]           tap_a, tap_b;
  logic [DL:1]          dl_q;
  logic [SP_WIDTH:0]    sp_q, sp_d, sp2;
  logic                 epoch_q, err_q;
  logic                 adv, wrap;
`ifdef CA_NCO_EPOCH_COUNT_EN
  logic [15:0]          epoch_count_q;
  assign epoch_count_o = epoch_count_q;
`endif

  // The seek engine owns the sample stream while busy.
  assign adv  = (state_q == S_SEEK) | enable_i;
  assign wrap = (cs_q == MAX_CS);
  assign cs_d = wrap ? '0 : cs_q + 1'b1;
  assign sum  = {1'b0, acc_q} + {1'b0, inc_i};

  // G2 phase-selector taps per PRN (register stages numbered 1..10).
  always_comb begin
    tap_a = 4'd4;
    tap_b = 4'd9;
    case (prn_i)
      5'd1:  begin tap_a = 4'd2; tap_b = 4'd6;  end
      5'd2:  begin tap_a = 4'd3; tap_b = 4'd7;  end
      5'd3:  begin tap_a = 4'd4; tap_b = 4'd8;  end
      5'd4:  begin tap_a = 4'd5; tap_b = 4'd9;  end
      5'd5:  begin tap_a = 4'd1; tap_b = 4'd9;  end
      5'd6:  begin tap_a = 4'd2; tap_b = 4'd10; end
      5'd7:  begin tap_a = 4'd1; tap_b = 4'd8;  end
      5'd8:  begin tap_a = 4'd2; tap_b = 4'd9;  end
      5'd9:  begin tap_a = 4'd3; tap_b = 4'd10; end
      5'd10: begin tap_a = 4'd2; tap_b = 4'd3;  end
      5'd11: begin tap_a = 4'd3; tap_b = 4'd4;  end
      5'd12: begin tap_a = 4'd5; tap_b = 4'd6;  end
      5'd13: begin tap_a = 4'd6; tap_b = 4'd7;  end
      5'd14: begin tap_a = 4'd7; tap_b = 4'd8;  end
      5'd15: begin tap_a = 4'd8; tap_b = 4'd9;  end
      5'd16: begin tap_a = 4'd9; tap_b = 4'd10; end
      5'd17: begin tap_a = 4'd1; tap_b = 4'd4;  end
      5'd18: begin tap_a = 4'd2; tap_b = 4'd5;  end
      5'd19: begin tap_a = 4'd3; tap_b = 4'd6;  end
      5'd20: begin tap_a = 4'd4; tap_b = 4'd7;  end
      5'd21: begin tap_a = 4'd5; tap_b = 4'd8;  end
      5'd22: begin tap_a = 4'd6; tap_b = 4'd9;  end
      5'd23: begin tap_a = 4'd1; tap_b = 4'd3;  end
      5'd24: begin tap_a = 4'd4; tap_b = 4'd6;  end
      5'd25: begin tap_a = 4'd5; tap_b = 4'd7;  end
      5'd26: begin tap_a = 4'd6; tap_b = 4'd8;  end
      5'd27: begin tap_a = 4'd7; tap_b = 4'd9;  end
      5'd28: begin tap_a = 4'd8; tap_b = 4'd10; end
      5'd29: begin tap_a = 4'd1; tap_b = 4'd6;  end
      5'd30: begin tap_a = 4'd2; tap_b = 4'd7;  end
      5'd31: begin tap_a = 4'd3; tap_b = 4'd8;  end
      default: begin tap_a = 4'd4; tap_b = 4'd9; end
    endcase
  end

  // Spacing is clamped into 1..MAX_SPACING and registered, so a new value
  // moves the taps on the following cycle without disturbing the line.
  always_comb begin
    sp_d = {1'b0, spacing_i};
    if (spacing_i == '0)
      sp_d = (SP_WIDTH+1)'(1);
    else if ({1'b0, spacing_i} > (SP_WIDTH+1)'(MAX_SPACING))
      sp_d = (SP_WIDTH+1)'(MAX_SPACING);
  end

  assign sp2 = sp_q << 1;

  assign out_early_o  = g1_q[10] ^ g2_q[tap_a] ^ g2_q[tap_b];
  assign out_prompt_o = dl_q[sp_q];
  assign out_late_o   = dl_q[sp2];
  assign code_shift_o = cs_q;
  assign epoch_o      = epoch_q;

  assign seek.seek_busy = (state_q == S_SEEK);
  assign seek.seek_done = (state_q == S_DONE);
  assign seek.seek_err  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cs_q     <= '0;
      target_q <= '0;
      acc_q    <= '0;
      g1_q     <= '1;
      g2_q     <= '1;
      dl_q     <= '0;
      sp_q     <= (SP_WIDTH+1)'(1);
      epoch_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef CA_NCO_EPOCH_COUNT_EN
      epoch_count_q <= '0;
`endif
    end else begin
      sp_q    <= sp_d;
      epoch_q <= adv & wrap;
      err_q   <= 1'b0;

      if (adv) begin
        cs_q <= cs_d;
        dl_q <= {dl_q[DL-1:1], out_early_o};
        if (wrap) begin
          // Period boundary: restart the code at chip 0 even if a chip
          // tick coincides with it.
          acc_q <= '0;
          g1_q  <= '1;
          g2_q  <= '1;
`ifdef CA_NCO_EPOCH_COUNT_EN
          epoch_count_q <= epoch_count_q + 16'd1;
`endif
        end else begin
          acc_q <= sum[ACC_WIDTH-1:0];
          if (sum[ACC_WIDTH]) begin
            g1_q <= {g1_q[9:1], g1_q[3] ^ g1_q[10]};
            g2_q <= {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
          end
        end
      end

      case (state_q)
        S_IDLE: begin
          if (seek.seek_start) begin
            if (seek.seek_target > MAX_CS)
              err_q <= 1'b1;
            else if (seek.seek_target == cs_q)
              state_q <= S_DONE;
            else begin
              state_q  <= S_SEEK;
              target_q <= seek.seek_target;
            end
          end
        end
        S_SEEK: begin
          // Abort wins even on the edge that would reach the target.
          if (seek.seek_abort)
            state_q <= S_IDLE;
          else if (cs_d == target_q)
            state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_code_nco.sv
module tb_ca_code_nco;

  localparam int MAXCS  = 16367;
  localparam int PERIOD = 16368;
  localparam longint TWO24 = 64'd16777216;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [4:0]  prn;
  logic [23:0] inc;
  logic [4:0]  spacing;
  logic [15:0] cs;
  logic        epoch, early, prompt, late;
`ifdef CA_NCO_EPOCH_COUNT_EN
  logic [15:0] epoch_count;
`endif

  ca_code_nco_if #(.CS_WIDTH(16)) sif ();

  ca_code_nco dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable),
    .prn_i        (prn),
    .inc_i        (inc),
    .spacing_i    (spacing),
    .seek         (sif),
    .code_shift_o (cs),
    .epoch_o      (epoch),
    .out_early_o  (early),
    .out_prompt_o (prompt),
    .out_late_o   (late)
`ifdef CA_NCO_EPOCH_COUNT_EN
    ,
    .epoch_count_o(epoch_count)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Reference: C/A code built as G1 xor (G2 delayed by the PRN's chip delay).
  bit g1s[1023];
  bit g2s[1023];
  int dly[1:32] = '{5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256, 257, 258,
                    469, 470, 471, 472, 473, 474, 509, 512, 513, 514, 515, 516, 859, 860, 861, 862};

  // Behavioural model state.
  int     m_cs, m_chip, m_state, m_target, m_sp, m_epcnt;
  longint m_acc;
  bit     m_epoch, m_err;
  bit     hist[1:32];

  function automatic bit code(int p, int k);
    return g1s[k] ^ g2s[(k + 1023 - dly[p]) % 1023];
  endfunction

  function automatic int clampsp(int s);
    if (s < 1) return 1;
    if (s > 16) return 16;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cs = 0; m_chip = 0; m_state = 0; m_target = 0; m_sp = 1; m_epcnt = 0;
    m_acc = 0; m_epoch = 0; m_err = 0;
    for (int j = 1; j <= 32; j++) hist[j] = 0;
  endtask

  task automatic check_all();
    check("code_shift", 32'(cs), 32'(m_cs));
    check("epoch", 32'(epoch), 32'(m_epoch));
    check("early", 32'(early), 32'(code(int'(prn), m_chip)));
    check("prompt", 32'(prompt), 32'(hist[m_sp]));
    check("late", 32'(late), 32'(hist[2 * m_sp]));
    check("busy", 32'(sif.seek_busy), 32'(m_state == 1));
    check("done", 32'(sif.seek_done), 32'(m_state == 2));
    check("err", 32'(sif.seek_err), 32'(m_err));
`ifdef CA_NCO_EPOCH_COUNT_EN
    check("epoch_count", 32'(epoch_count), 32'(m_epcnt));
`endif
  endtask

  // One clock edge: the model consumes the inputs present at the edge.
  task automatic tick();
    bit adv;
    int cs_old;
    @(posedge clk);
    adv     = (m_state == 1) || enable;
    cs_old  = m_cs;
    m_epoch = 0;
    m_err   = 0;
    if (adv) begin
      for (int j = 32; j >= 2; j--) hist[j] = hist[j-1];
      hist[1] = code(int'(prn), m_chip);
      if (m_cs == MAXCS) begin
        m_cs = 0; m_acc = 0; m_chip = 0; m_epoch = 1;
        m_epcnt = (m_epcnt + 1) % 65536;
      end else begin
        m_cs++;
        m_acc += longint'(inc);
        if (m_acc >= TWO24) begin
          m_acc -= TWO24;
          m_chip = (m_chip + 1) % 1023;
        end
      end
    end
    m_sp = clampsp(int'(spacing));
    case (m_state)
      0: if (sif.seek_start) begin
           if (int'(sif.seek_target) > MAXCS) m_err = 1;
           else if (int'(sif.seek_target) == cs_old) m_state = 2;
           else begin m_state = 1; m_target = int'(sif.seek_target); end
         end
      1: if (sif.seek_abort) m_state = 0;
         else if (m_cs == m_target) m_state = 2;
      default: m_state = 0;
    endcase
    #1;
    check_all();
  endtask

  task automatic start_seek(input int target);
    sif.seek_start  = 1'b1;
    sif.seek_target = 16'(target);
    tick();
    sif.seek_start  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] anchor;
    logic [9:0] prn1_first;
    logic [9:0] r1, r2;
    int n_epoch, busy_cycles, start_cs, guard;

    r1 = '1; r2 = '1;
    for (int i = 0; i < 1023; i++) begin
      g1s[i] = r1[9];
      g2s[i] = r2[9];
      r1 = {r1[8:0], r1[2] ^ r1[9]};
      r2 = {r2[8:0], r2[1] ^ r2[2] ^ r2[5] ^ r2[7] ^ r2[8] ^ r2[9]};
    end
    prn1_first = 10'b1100100000;  // PRN 1 first chips, octal 1440

    enable = 0; prn = 5'd1; inc = 24'h100000; spacing = 5'd8;
    sif.seek_start = 0; sif.seek_target = '0; sif.seek_abort = 0;

    // Reset before any clock edge.
    rst = 1'b1;
    #3;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset values checked");

    // Free run one full period plus 50 samples at nominal rate.
    enable = 1; anchor = '0; n_epoch = 0;
    for (int n = 0; n < PERIOD + 50; n++) begin
      if (n < 160 && n % 16 == 0) anchor = {anchor[8:0], early};
      tick();
      if (epoch) n_epoch++;
    end
    check("prn1_first_chips", 32'(anchor), 32'(prn1_first));
    check("epochs_in_period", 32'(n_epoch), 32'd1);
    check("cs_after_period", 32'(cs), 32'd50);
    $display("[TB] free run: %0d epochs, code_shift=%0d", n_epoch, cs);

    // Spacing sweep, including clamp boundaries.
    spacing = 5'd0;  repeat (40) tick();
    spacing = 5'd31; repeat (40) tick();
    spacing = 5'd8;  repeat (40) tick();
    $display("[TB] spacing sweep 0/31/8 done");

    // Reset mid-seek and mid-chip, checked before the next clock edge.
    enable = 0;
    start_seek((m_cs + 500) % PERIOD);
    repeat (7) tick();
    #2;
    do_reset();
    check("reset_busy", 32'(sif.seek_busy), 32'd0);
    $display("[TB] asynchronous reset mid-seek checked");

    // Bring code_shift to 100.
    enable = 1; repeat (100) tick();
    enable = 0; tick();
    check("cs_at_100", 32'(cs), 32'd100);

    // Seek to the current position and to an out-of-range target.
    start_seek(100);
    check("seek_same_done", 32'(sif.seek_done), 32'd1);
    check("seek_same_cs", 32'(cs), 32'd100);
    tick();
    start_seek(PERIOD);
    check("seek_range_err", 32'(sif.seek_err), 32'd1);
    check("seek_range_cs", 32'(cs), 32'd100);
    tick();
    $display("[TB] seek to self / out-of-range checked");

    // Seek 100 -> 50 with enable low, wrapping through the period end.
    start_seek(50);
    busy_cycles = 0; n_epoch = 0; guard = 0;
    while (sif.seek_busy && guard < 20000) begin
      busy_cycles++; guard++;
      tick();
      if (epoch) n_epoch++;
    end
    check("seek_busy_cycles", 32'(busy_cycles), 32'd16318);
    check("seek_epochs", 32'(n_epoch), 32'd1);
    check("seek_end_cs", 32'(cs), 32'd50);
    check("seek_end_done", 32'(sif.seek_done), 32'd1);
    tick();
    $display("[TB] seek 100->50: busy %0d cycles, %0d epochs", busy_cycles, n_epoch);

    // Abort on the 10th seek advance.
    start_cs = m_cs;
    start_seek((start_cs + 1000) % PERIOD);
    repeat (9) tick();
    sif.seek_abort = 1; tick(); sif.seek_abort = 0;
    check("abort_busy", 32'(sif.seek_busy), 32'd0);
    check("abort_cs", 32'(cs), 32'((start_cs + 10) % PERIOD));
    repeat (5) begin
      tick();
      check("abort_no_done", 32'(sif.seek_done), 32'd0);
    end
    $display("[TB] abort checked, code_shift=%0d", cs);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: inc = 24'($urandom);
        1: inc = 24'hFFFFFF;
        2: inc = 24'h000000;
        default: inc = 24'h100000 + 24'($urandom_range(0, 4095));
      endcase
      if ($urandom_range(0, 19) == 0) spacing = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 499) == 0) prn = 5'($urandom_range(1, 31));
      if (m_state == 0 && $urandom_range(0, 39) == 0) begin
        sif.seek_start = 1;
        if ($urandom_range(0, 7) == 0)
          sif.seek_target = 16'(PERIOD + $urandom_range(0, 40000));
        else
          sif.seek_target = 16'((m_cs + $urandom_range(0, 80)) % PERIOD);
      end
      if (m_state == 1 && $urandom_range(0, 29) == 0) sif.seek_abort = 1;
      tick();
      sif.seek_start = 0;
      sif.seek_abort = 0;
    end
    $display("[TB] random traffic: 3000 cycles");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
